// File: rtl/wts_channel_part_ex.sv
// Single wave-table sound channel with three parts:
//   - an ADSR envelope FSM driven by a rate accumulator,
//   - a wave-address generator clocked by a frequency divider,
//   - a 17-bit LFSR noise source that gates the envelope.
// All state advances only on cycles where `active` is high.
module wts_channel_part_ex #(
    parameter int unsigned ENV_BITS  = 9,
    parameter int unsigned ADDR_BITS = 7,
    parameter int unsigned FREQ_BITS = 12,
    parameter int unsigned RATE_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    input  logic                 key_on,
    input  logic                 key_release,
    input  logic                 key_off,
    input  logic [1:0]           reg_noise_mode,
    input  logic [RATE_BITS-1:0] reg_ar,
    input  logic [RATE_BITS-1:0] reg_dr,
    input  logic [RATE_BITS-1:0] reg_sr,
    input  logic [RATE_BITS-1:0] reg_rr,
    input  logic [7:0]           reg_sl,
    input  logic [1:0]           reg_wave_length,
    input  logic [FREQ_BITS-1:0] reg_frequency_count,
    output logic [ENV_BITS-1:0]  envelope,
    output logic [ADDR_BITS-1:0] sram_a,
    output logic [2:0]           env_state,
    output logic                 busy
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } env_state_e;

    localparam logic [ENV_BITS-1:0]  EnvMax   = '1;
    localparam logic [ADDR_BITS-1:0] AddrOnes = '1;
    localparam logic [16:0]          LfsrSeed = 17'h00001;

    env_state_e           state_q, state_d;
    logic [ENV_BITS-1:0]  level_q, level_d;
    logic [RATE_BITS-1:0] acc_q, acc_d;
    logic [FREQ_BITS-1:0] div_q, div_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [16:0]          lfsr_q, lfsr_d;
    logic [ENV_BITS-1:0]  envelope_q, envelope_d;

    logic [RATE_BITS-1:0] rate;
    logic [RATE_BITS:0]   sum;
    logic                 step;
    logic [ENV_BITS-1:0]  level_inc;
    logic [ENV_BITS-1:0]  level_dec;
    logic [ENV_BITS-1:0]  target;
    logic                 key_on_eff;
    logic                 tick;
    logic [ADDR_BITS-1:0] wave_mask;

    // key_off outranks key_on everywhere, including the address/divider restart.
    assign key_on_eff = key_on & ~key_off;

    // Envelope FSM: key handling, rate accumulator and level stepping.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        acc_d     = acc_q;
        level_inc = level_q + ENV_BITS'(1);
        level_dec = level_q - ENV_BITS'(1);
        target    = ENV_BITS'(reg_sl) << (ENV_BITS - 8);

        unique case (state_q)
            StAttack:  rate = reg_ar;
            StDecay:   rate = reg_dr;
            StSustain: rate = reg_sr;
            StRelease: rate = reg_rr;
            default:   rate = '0;
        endcase
        sum  = {1'b0, acc_q} + {1'b0, rate};
        step = sum[RATE_BITS];

        if (active) begin
            if (key_off) begin
                state_d = StIdle;
                level_d = '0;
                acc_d   = '0;
            end else if (key_on) begin
                state_d = StAttack;
                level_d = '0;
                acc_d   = '0;
            end else if (key_release &&
                         (state_q inside {StAttack, StDecay, StSustain})) begin
                state_d = StRelease;
                acc_d   = '0;
            end else begin
                acc_d = sum[RATE_BITS-1:0];
                unique case (state_q)
                    StAttack: begin
                        if (level_q == EnvMax) begin
                            state_d = StDecay;
                            acc_d   = '0;
                        end else if (step) begin
                            level_d = level_inc;
                            if (level_inc == EnvMax) begin
                                state_d = StDecay;
                                acc_d   = '0;
                            end
                        end
                    end
                    StDecay: begin
                        if (target >= EnvMax) begin
                            state_d = StSustain;
                            acc_d   = '0;
                        end else if (level_q <= target) begin
                            // Sustain level raised above current level: snap to it.
                            level_d = target;
                            state_d = StSustain;
                            acc_d   = '0;
                        end else if (step) begin
                            if (level_dec <= target) begin
                                level_d = target;
                                state_d = StSustain;
                                acc_d   = '0;
                            end else begin
                                level_d = level_dec;
                            end
                        end
                    end
                    StSustain: begin
                        if (step && (level_q != '0)) begin
                            level_d = level_dec;
                        end
                    end
                    StRelease: begin
                        if (level_q == '0) begin
                            state_d = StIdle;
                            acc_d   = '0;
                        end else if (step) begin
                            level_d = level_dec;
                            if (level_dec == '0) begin
                                state_d = StIdle;
                                acc_d   = '0;
                            end
                        end
                    end
                    default: begin
                        // Idle, or recovery from an unused encoding.
                        state_d = StIdle;
                        acc_d   = '0;
                    end
                endcase
            end
        end
    end

    // Divider, wave address and LFSR; all advance on the divider tick.
    always_comb begin
        div_d     = div_q;
        addr_d    = addr_q;
        lfsr_d    = lfsr_q;
        tick      = 1'b0;
        // Shift amount may equal ADDR_BITS, which yields an all-ones mask.
        wave_mask = ~(AddrOnes << ((ADDR_BITS - 3) + reg_wave_length));

        if (active) begin
            if (key_on_eff) begin
                addr_d = '0;
                div_d  = reg_frequency_count;
            end else begin
                if (div_q == '0) begin
                    div_d = reg_frequency_count;
                    tick  = 1'b1;
                end else begin
                    div_d = div_q - FREQ_BITS'(1);
                end
                if (tick) begin
                    addr_d = (addr_q + ADDR_BITS'(1)) & wave_mask;
                    if (reg_noise_mode != 2'd0) begin
                        lfsr_d = {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
                    end
                end
            end
        end
    end

    // Output mux uses next-state level/noise so the register adds one cycle of latency.
    always_comb begin
        case (reg_noise_mode)
            2'd0:    envelope_d = level_d;
            2'd2:    envelope_d = lfsr_d[0] ? '0 : level_d;
            default: envelope_d = lfsr_d[0] ? level_d : '0;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            level_q    <= '0;
            acc_q      <= '0;
            div_q      <= '0;
            addr_q     <= '0;
            lfsr_q     <= LfsrSeed;
            envelope_q <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            acc_q      <= acc_d;
            div_q      <= div_d;
            addr_q     <= addr_d;
            lfsr_q     <= lfsr_d;
            envelope_q <= envelope_d;
        end
    end

    assign envelope  = envelope_q;
    assign sram_a    = addr_q;
    assign env_state = state_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_wts_channel_part_ex.sv
// Directed bench for wts_channel_part_ex: ADSR timing, key priority, tone
// addressing, async reset, active gating and noise gating.
module tb_wts_channel_part_ex;

    localparam int unsigned ENV_BITS  = 9;
    localparam int unsigned ADDR_BITS = 7;
    localparam int unsigned FREQ_BITS = 12;
    localparam int unsigned RATE_BITS = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 active;
    logic                 key_on;
    logic                 key_release;
    logic                 key_off;
    logic [1:0]           reg_noise_mode;
    logic [RATE_BITS-1:0] reg_ar;
    logic [RATE_BITS-1:0] reg_dr;
    logic [RATE_BITS-1:0] reg_sr;
    logic [RATE_BITS-1:0] reg_rr;
    logic [7:0]           reg_sl;
    logic [1:0]           reg_wave_length;
    logic [FREQ_BITS-1:0] reg_frequency_count;
    logic [ENV_BITS-1:0]  envelope;
    logic [ADDR_BITS-1:0] sram_a;
    logic [2:0]           env_state;
    logic                 busy;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] m;

    wts_channel_part_ex #(
        .ENV_BITS (ENV_BITS),
        .ADDR_BITS(ADDR_BITS),
        .FREQ_BITS(FREQ_BITS),
        .RATE_BITS(RATE_BITS)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .active             (active),
        .key_on             (key_on),
        .key_release        (key_release),
        .key_off            (key_off),
        .reg_noise_mode     (reg_noise_mode),
        .reg_ar             (reg_ar),
        .reg_dr             (reg_dr),
        .reg_sr             (reg_sr),
        .reg_rr             (reg_rr),
        .reg_sl             (reg_sl),
        .reg_wave_length    (reg_wave_length),
        .reg_frequency_count(reg_frequency_count),
        .envelope           (envelope),
        .sram_a             (sram_a),
        .env_state          (env_state),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_on();
        key_on = 1'b1;
        cyc();
        key_on = 1'b0;
    endtask

    task automatic pulse_release();
        key_release = 1'b1;
        cyc();
        key_release = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        active              = 1'b0;
        key_on              = 1'b0;
        key_release         = 1'b0;
        key_off             = 1'b0;
        reg_noise_mode      = 2'd0;
        reg_ar              = 16'h8000;
        reg_dr              = 16'h8000;
        reg_sr              = 16'h0000;
        reg_rr              = 16'h0000;
        reg_sl              = 8'h80;
        reg_wave_length     = 2'd0;
        reg_frequency_count = 12'd3;
        repeat (3) cyc();
        check("rst_env", 32'(envelope), 0);
        check("rst_addr", 32'(sram_a), 0);
        check("rst_state", 32'(env_state), 0);
        check("rst_busy", 32'(busy), 0);

        // ADSR sweep
        reset  = 1'b0;
        active = 1'b1;
        cyc();
        pulse_on();
        check("att_state", 32'(env_state), 1);
        check("att_busy", 32'(busy), 1);
        check("att_env0", 32'(envelope), 0);
        repeat (1021) cyc();
        check("att_env510", 32'(envelope), 510);
        check("att_state510", 32'(env_state), 1);
        cyc();
        check("att_env511", 32'(envelope), 511);
        check("dec_enter", 32'(env_state), 2);
        repeat (509) cyc();
        check("dec_env257", 32'(envelope), 257);
        check("dec_state257", 32'(env_state), 2);
        cyc();
        check("sus_env256", 32'(envelope), 256);
        check("sus_enter", 32'(env_state), 3);
        repeat (20) cyc();
        check("sus_hold", 32'(envelope), 256);
        check("sus_state", 32'(env_state), 3);
        reg_rr = 16'hFFFF;
        pulse_release();
        check("rel_env", 32'(envelope), 256);
        check("rel_state", 32'(env_state), 4);
        repeat (256) cyc();
        check("rel_env1", 32'(envelope), 1);
        check("rel_state1", 32'(env_state), 4);
        cyc();
        check("rel_env0", 32'(envelope), 0);
        check("rel_idle", 32'(env_state), 0);
        check("rel_busy", 32'(busy), 0);

        // Key priority
        pulse_release();
        check("idle_rel_state", 32'(env_state), 0);
        check("idle_rel_env", 32'(envelope), 0);
        pulse_on();
        repeat (10) cyc();
        check("pri_env5", 32'(envelope), 5);
        key_on      = 1'b1;
        key_release = 1'b1;
        cyc();
        key_on      = 1'b0;
        key_release = 1'b0;
        check("on_over_rel_state", 32'(env_state), 1);
        check("on_over_rel_env", 32'(envelope), 0);
        repeat (10) cyc();
        check("pri_env5b", 32'(envelope), 5);
        key_on  = 1'b1;
        key_off = 1'b1;
        cyc();
        key_on  = 1'b0;
        key_off = 1'b0;
        check("off_over_on_state", 32'(env_state), 0);
        check("off_over_on_env", 32'(envelope), 0);
        check("off_over_on_busy", 32'(busy), 0);

        // Tone addressing, L=16 then L=32
        pulse_on();
        check("tone_addr0", 32'(sram_a), 0);
        repeat (3) cyc();
        check("tone_addr_c3", 32'(sram_a), 0);
        cyc();
        check("tone_addr_c4", 32'(sram_a), 1);
        repeat (56) cyc();
        check("tone_addr_c60", 32'(sram_a), 15);
        repeat (3) cyc();
        check("tone_addr_c63", 32'(sram_a), 15);
        cyc();
        check("tone_wrap", 32'(sram_a), 0);
        repeat (36) cyc();
        check("tone_addr9", 32'(sram_a), 9);
        pulse_on();
        check("keyon_addr_clr", 32'(sram_a), 0);
        reg_wave_length = 2'd1;
        pulse_on();
        repeat (64) cyc();
        check("wl1_addr16", 32'(sram_a), 16);
        repeat (64) cyc();
        check("wl1_wrap", 32'(sram_a), 0);
        reg_wave_length = 2'd0;

        // Async reset mid-attack
        pulse_on();
        repeat (200) cyc();
        check("mid_env100", 32'(envelope), 100);
        check("mid_addr2", 32'(sram_a), 2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_env", 32'(envelope), 0);
        check("arst_addr", 32'(sram_a), 0);
        check("arst_state", 32'(env_state), 0);
        check("arst_busy", 32'(busy), 0);
        cyc();
        check("rst_hold_env", 32'(envelope), 0);
        reset = 1'b0;

        // Active gating
        pulse_on();
        repeat (10) cyc();
        check("gate_pre_env", 32'(envelope), 5);
        check("gate_pre_addr", 32'(sram_a), 2);
        active = 1'b0;
        for (int i = 0; i < 100; i++) begin
            key_on = i[0];
            cyc();
        end
        key_on = 1'b0;
        check("gate_env", 32'(envelope), 5);
        check("gate_addr", 32'(sram_a), 2);
        check("gate_state", 32'(env_state), 1);
        active = 1'b1;

        // Noise gating with level held at full scale
        reset = 1'b1;
        cyc();
        reset               = 1'b0;
        reg_frequency_count = 12'd0;
        reg_ar              = 16'hFFFF;
        reg_dr              = 16'h0000;
        reg_noise_mode      = 2'd0;
        pulse_on();
        repeat (520) cyc();
        check("nz_full", 32'(envelope), 511);
        check("nz_state", 32'(env_state), 2);
        repeat (5) cyc();
        check("nz_mode0", 32'(envelope), 511);
        m              = 17'h00001;
        reg_noise_mode = 2'd1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            m = {m[15:0], m[16] ^ m[13]};
            check("nz_mode1", 32'(envelope), m[0] ? 511 : 0);
        end
        reg_noise_mode = 2'd2;
        for (int i = 0; i < 20; i++) begin
            cyc();
            m = {m[15:0], m[16] ^ m[13]};
            check("nz_mode2", 32'(envelope), m[0] ? 0 : 511);
        end
        reg_noise_mode = 2'd3;
        for (int i = 0; i < 10; i++) begin
            cyc();
            m = {m[15:0], m[16] ^ m[13]};
            check("nz_mode3", 32'(envelope), m[0] ? 511 : 0);
        end
        reg_noise_mode = 2'd0;
        cyc();
        check("nz_back_mode0", 32'(envelope), 511);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wts_channel_part_ex.md
Name: wts_channel_part_ex

Overview:
Parametrised next-generation single channel for the wave table sound engine. Contains an ADSR envelope FSM, a wave-address generator whose address is reset on key-on, and an LFSR noise source with selectable mix mode. All widths are generic. Sits between the register file (reg_* inputs, key pulses) and the channel mixer/SRAM (envelope, sram_a).

Parameters:
ENV_BITS, 9, envelope width; full scale ENV_MAX = 2^ENV_BITS-1
ADDR_BITS, 7, wave SRAM address width (>=4)
FREQ_BITS, 12, frequency divider width
RATE_BITS, 16, ADSR rate register and accumulator width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
active  in  1  3.579MHz timing pulse; all state advances only when 1
key_on  in  1  pulse: start attack, reset wave address
key_release  in  1  pulse: enter release
key_off  in  1  pulse: immediate silence
reg_noise_mode  in  2  0 tone, 1 noise gate, 2 inverted noise gate, 3 = mode 1
reg_ar / reg_dr / reg_sr / reg_rr  in  RATE_BITS each  attack/decay/sustain/release rate
reg_sl  in  8  sustain level
reg_wave_length  in  2  wave length select
reg_frequency_count  in  FREQ_BITS  divider reload
envelope  out  ENV_BITS  gated envelope, registered
sram_a  out  ADDR_BITS  wave sample address, registered
env_state  out  3  0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
busy  out  1  env_state != IDLE

Behaviour:
- Reset: envelope=0, sram_a=0, env_state=IDLE, busy=0, rate accumulator=0, divider=0, LFSR=17'h00001.
- Key pulses sampled only with active=1; priority key_off > key_on > key_release. Pulses with active=0 are ignored.
- Rate engine: each active cycle in ATTACK/DECAY/SUSTAIN/RELEASE, acc <= acc + rate (RATE_BITS, wraps); carry-out is one step (+/-1 to level). Rate 0 = hold. acc cleared on every state change and on key_on.
- ATTACK: level +1 per step; reaching ENV_MAX -> DECAY.
- DECAY: target = reg_sl << (ENV_BITS-8). Level -1 per step; when level <= target, clamp level to target and go to SUSTAIN. If target >= ENV_MAX, go to SUSTAIN immediately.
- SUSTAIN: level -1 per step at reg_sr, saturates at 0 and stays in SUSTAIN.
- RELEASE: level -1 per step at reg_rr; reaching 0 -> IDLE.
- key_on from any state: level=0, ATTACK. key_release from ATTACK/DECAY/SUSTAIN: RELEASE, level kept. Ignored in IDLE/RELEASE. key_off: level=0, IDLE.
- Divider: counts down on active. When it is 0, it reloads reg_frequency_count and emits a tick. Reload 0 = a tick every active cycle.
- Wave address: on tick, addr increments modulo L, where L = 2^(ADDR_BITS-3+reg_wave_length); upper bits are forced 0. key_on sets addr=0 and divider=reg_frequency_count in the same cycle. A reg_wave_length change takes effect on the next tick (addr masked).
- LFSR: 17-bit Fibonacci, x^17+x^14+1, shifts on each tick when reg_noise_mode!=0. The noise bit is LFSR[0].
- Output mux (registered): mode 0 envelope=level; mode 1/3 envelope = noise ? level : 0; mode 2 envelope = noise ? 0 : level.
- Latency: envelope, sram_a and env_state reflect an active cycle's update on the following clk edge (1 cycle).
- Reset asserted mid-note returns everything to reset values immediately. No output glitch to non-zero while reset=1.

Test Plan:
- Reset: reset=1 mid-ATTACK (level 100) -> envelope=0, sram_a=0, env_state=0, busy=0 asynchronously.
- ADSR: active every cycle, ar=16'h8000, dr=16'h8000, sl=8'h80, sr=0, key_on -> ATTACK reaches 511 after 1022 active cycles. DECAY then reaches 256 after 510 more, SUSTAIN holds 256. key_release with rr=16'hFFFF -> IDLE after ~256 steps.
- Priority: key_on and key_off in the same active cycle -> IDLE, envelope 0. key_release in IDLE -> no change.
- Tone: reg_frequency_count=3, reg_wave_length=0 (L=16) -> sram_a advances every 4 active cycles and wraps 15->0. key_on at addr 9 -> sram_a=0 next cycle.
- Noise: mode 1, freq=0, level held at 511 -> envelope tracks LFSR[0] sequence from seed 1 (0,0,...,1 per x^17+x^14+1). Mode 2 gives the complement. Mode 0 gives a constant 511.
- Active gating: active=0 for 100 cycles with key_on pulsing -> no state or output change.
